// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Queue entries carry the fetched PC alongside its instruction word.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR =
    32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT =
    32'h0100_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} pairs with flush.
// Push and pop may happen in the same cycle, including when full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads imemory, queues fetches for decode.
// A redirect flushes the queue and restarts at an aligned target.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC =
    RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic [XLEN-1:0] imem_address,
  output logic            imem_read_write,
  output logic [XLEN-1:0] imem_data_in,
  input  logic [XLEN-1:0] imem_data_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            fetch_misalign
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            push, pop;
  logic            q_full, q_empty;
  fetch_entry_t    wr_entry, rd_entry;

  assign imem_address    = pc_q;
  assign imem_read_write = 1'b0;
  assign imem_data_in    = '0;

  assign if_valid = ~q_empty;
  assign if_pc    = q_empty ? '0 : rd_entry.pc;
  assign if_instr = q_empty ? NOP_INSTR
                            : rd_entry.instr;
  assign fetch_misalign = misalign_q;

  assign pop  = if_valid & id_ready
              & ~redirect_valid;
  assign push = ~redirect_valid
              & (~q_full | pop);

  assign wr_entry = '{pc: pc_q,
                      instr: imem_data_out};

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    unique case (1'b1)
      redirect_valid: begin
        pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
        misalign_d = misalign_q
                   | (|redirect_pc[1:0]);
      end
      push: pc_d = pc_q + 32'd4;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (redirect_valid),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .full     (q_full),
    .empty    (q_empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table then
// randomized traffic against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] A   = 32'h0100_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          DEP = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic [31:0] imem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_misalign;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] imem_fn(
    input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data_out = imem_fn(imem_address);

  fetch_stage dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .imem_address    (imem_address),
    .imem_read_write (imem_read_write),
    .imem_data_in    (imem_data_in),
    .imem_data_out   (imem_data_out),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .fetch_misalign  (fetch_misalign)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk_all(input string tag,
                         input bit ev,
                         input logic [31:0] epc,
                         input logic [31:0] eaddr,
                         input bit emis);
    logic [31:0] ein;
    ein = ev ? imem_fn(epc) : NOP;
    chk({tag, " if_valid"}, 32'(if_valid), 32'(ev));
    chk({tag, " if_pc"}, if_pc, ev ? epc : 32'h0);
    chk({tag, " if_instr"}, if_instr, ein);
    chk({tag, " imem_addr"}, imem_address, eaddr);
    chk({tag, " misalign"},
        32'(fetch_misalign), 32'(emis));
    chk({tag, " imem_rw"}, 32'(imem_read_write), 32'h0);
    chk({tag, " imem_din"}, imem_data_in, 32'h0);
  endtask

  typedef struct {
    bit          rst_n;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    bit          emis;
  } vec_t;

  function automatic vec_t mk(
    input bit rn, input bit rv,
    input logic [31:0] rp, input bit rd,
    input bit ev, input logic [31:0] ep,
    input logic [31:0] ea, input bit em);
    vec_t v;
    v.rst_n = rn; v.redir = rv; v.rpc = rp;
    v.rdy = rd; v.ev = ev; v.epc = ep;
    v.eaddr = ea; v.emis = em;
    return v;
  endfunction

  // reference model state
  logic [31:0] m_pc;
  bit          m_mis;
  logic [63:0] m_q[$];

  task automatic model_step(input bit rn,
                            input bit rv,
                            input logic [31:0] rp,
                            input bit rd);
    int  sz;
    bit  do_pop;
    if (!rn) begin
      m_pc = A; m_mis = 0; m_q.delete();
    end else if (rv) begin
      m_q.delete();
      m_pc  = rp & 32'hFFFF_FFFC;
      m_mis = m_mis | (rp[1:0] != 2'b00);
    end else begin
      sz     = m_q.size();
      do_pop = (sz > 0) && rd;
      if (do_pop) void'(m_q.pop_front());
      if (sz < DEP || do_pop) begin
        m_q.push_back({m_pc, imem_fn(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  vec_t tbl[28];

  initial begin
    logic [63:0] hd;
    bit          rn, rv, rd;
    logic [31:0] rp;

    tbl[0]  = mk(1,0,0,1, 0,0,A,0);
    tbl[1]  = mk(1,0,0,1, 1,A,A+4,0);
    tbl[2]  = mk(1,0,0,1, 1,A+4,A+8,0);
    tbl[3]  = mk(1,0,0,0, 1,A+8,A+12,0);
    tbl[4]  = mk(1,0,0,0, 1,A+8,A+16,0);
    tbl[5]  = mk(1,0,0,0, 1,A+8,A+16,0);
    tbl[6]  = mk(1,0,0,0, 1,A+8,A+16,0);
    tbl[7]  = mk(1,0,0,0, 1,A+8,A+16,0);
    tbl[8]  = mk(1,0,0,1, 1,A+8,A+16,0);
    tbl[9]  = mk(1,0,0,1, 1,A+12,A+20,0);
    tbl[10] = mk(1,0,0,0, 1,A+16,A+24,0);
    tbl[11] = mk(1,1,A+32'h40,1, 1,A+16,A+24,0);
    tbl[12] = mk(1,0,0,1, 0,0,A+32'h40,0);
    tbl[13] = mk(1,0,0,0, 1,A+32'h40,A+32'h44,0);
    tbl[14] = mk(1,1,A+32'h46,0,
                 1,A+32'h40,A+32'h48,0);
    tbl[15] = mk(1,0,0,1, 0,0,A+32'h44,1);
    tbl[16] = mk(1,0,0,1,
                 1,A+32'h44,A+32'h48,1);
    tbl[17] = mk(1,1,32'hFFFF_FFFC,1,
                 1,A+32'h48,A+32'h4C,1);
    tbl[18] = mk(1,0,0,1, 0,0,32'hFFFF_FFFC,1);
    tbl[19] = mk(1,0,0,1, 1,32'hFFFF_FFFC,0,1);
    tbl[20] = mk(1,0,0,0, 1,0,4,1);
    tbl[21] = mk(1,1,32'h200,1, 1,0,8,1);
    tbl[22] = mk(1,1,32'h303,1, 0,0,32'h200,1);
    tbl[23] = mk(1,0,0,0, 0,0,32'h300,1);
    tbl[24] = mk(1,0,0,0, 1,32'h300,32'h304,1);
    tbl[25] = mk(0,1,32'h500,1,
                 1,32'h300,32'h308,1);
    tbl[26] = mk(1,0,0,0, 0,0,A,0);
    tbl[27] = mk(1,0,0,0, 1,A,A+4,0);

    reset_n = 0; redirect_valid = 0;
    redirect_pc = 0; id_ready = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);

    for (int i = 0; i < 28; i++) begin
      reset_n        = tbl[i].rst_n;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      id_ready       = tbl[i].rdy;
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].ev,
              tbl[i].epc, tbl[i].eaddr, tbl[i].emis);
      @(posedge clock);
      @(negedge clock);
    end

    reset_n = 0; redirect_valid = 0;
    @(posedge clock);
    model_step(0, 0, 0, 0);
    @(negedge clock);

    for (int c = 0; c < 2000; c++) begin
      rn = ($urandom_range(0, 59) != 0);
      rv = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0)
        rp = 32'hFFFF_FFF0
           | 32'($urandom_range(0, 15));
      else
        rp = $urandom;
      reset_n = rn; redirect_valid = rv;
      redirect_pc = rp; id_ready = rd;
      #1;
      if (m_q.size() > 0) begin
        hd = m_q[0];
        chk_all("rnd", 1, hd[63:32], m_pc, m_mis);
      end else begin
        chk_all("rnd", 0, 0, m_pc, m_mis);
      end
      model_step(rn, rv, rp, rd);
      @(posedge clock);
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
